// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   SIZE_B / SIZE_H / SIZE_W : encodings of mem_size_i (2'b11 is handled as a word)
//   state_t                  : responder FSM states
//   LAT_W                    : width of the latency counter (LATENCY up to 15)
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int LAT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Lane handling for the data memory (purely combinational).
//   lane_i     : byte address bits [1:0] of the access
//   size_i     : access size (byte / half / word, 2'b11 = word)
//   unsigned_i : 1 zero-extends a sub-word load, 0 sign-extends
//   wdata_i    : store data, sub-word data taken from its low byte/half
//   rword_i    : full 32-bit word currently stored at the addressed index
//   be_o       : byte enables for the store
//   wdata_o    : store data replicated onto every lane
//   rdata_o    : selected and extended load data
// Misaligned half/word accesses are forced aligned here: a half uses
// lane_i[1] only and a word ignores lane_i altogether.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
    be_o     = 4'b1111;
    wdata_o  = wdata_i;
    rdata_o  = rword_i;
    case (size_i)
      SIZE_B: begin
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      end
      SIZE_H: begin
        be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store interface.
// Accepts one load/store, holds it LATENCY cycles, then commits the store
// or returns the extended load data with a one-cycle ready pulse.
//   clk, rst_n       : clock, asynchronous active-low reset
//   mem_read_i       : load request
//   mem_write_i      : store request (wins over read)
//   mem_addr_i       : byte address, wraps modulo the array size
//   mem_wdata_i      : store data
//   mem_size_i       : 00 byte, 01 half, 10/11 word
//   mem_unsigned_i   : load zero-extension select
//   mem_ready_o      : response pulse
//   mem_rdata_o      : last load result
//   mem_busy_o       : stall request while the access is in flight
//   mem_err_o        : misaligned-access flag
// Optional feature macro: DMEM_MISALIGN_ERR_EN (misaligned accesses flagged
// and suppressed instead of being forced aligned).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_busy_o,
  output logic        mem_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(LATENCY - 1);

  state_t           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [AW+1:0]    addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic             write_q, write_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [31:0] mem_array [DEPTH_WORDS];

  logic          req, accept, wait_last, fire, mem_we, misaligned;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_wdata, acc_word, st_data, ld_data;
  logic [1:0]    acc_size;
  logic          acc_uns, acc_write;
  logic [AW-1:0] acc_idx;
  logic [3:0]    st_be;
  logic          unused_addr_hi;

  // Address bits above the array are ignored, giving modulo wrap.
  assign unused_addr_hi = ^mem_addr_i[31:AW+2];

  assign req       = mem_read_i | mem_write_i;
  assign accept    = (state_q == ST_IDLE) & req;
  assign wait_last = (state_q == ST_WAIT) & (cnt_q <= LAT_W'(1));
  // With LATENCY=1 the access happens on the acceptance edge itself,
  // so the operands come straight from the ports while in IDLE.
  assign fire      = (accept & (LATENCY == 1)) | wait_last;

  assign acc_addr  = (state_q == ST_IDLE) ? mem_addr_i[AW+1:0] : addr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? mem_wdata_i        : wdata_q;
  assign acc_size  = (state_q == ST_IDLE) ? mem_size_i         : size_q;
  assign acc_uns   = (state_q == ST_IDLE) ? mem_unsigned_i     : uns_q;
  assign acc_write = (state_q == ST_IDLE) ? mem_write_i        : write_q;
  assign acc_idx   = acc_addr[AW+1:2];
  assign acc_word  = mem_array[acc_idx];

`ifdef DMEM_MISALIGN_ERR_EN
  assign misaligned = ((acc_size == SIZE_H) & acc_addr[0]) |
                      (acc_size[1] & (acc_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // rst_n gates the write so an access aborted by reset never commits.
  assign mem_we = fire & acc_write & ~misaligned & rst_n;

  dmem_lane_align u_lane_align (
    .lane_i     (acc_addr[1:0]),
    .size_i     (acc_size),
    .unsigned_i (acc_uns),
    .wdata_i    (acc_wdata),
    .rword_i    (acc_word),
    .be_o       (st_be),
    .wdata_o    (st_data),
    .rdata_o    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem_array[acc_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = (LATENCY == 1) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (wait_last) state_d = ST_DONE;
      // A request seen in DONE is the stalled old one; never accept it here.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, latency counter and load result
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    write_d = write_q;
    rdata_d = rdata_q;
    if (accept) begin
      cnt_d   = LAT_M1;
      addr_d  = mem_addr_i[AW+1:0];
      wdata_d = mem_wdata_i;
      size_d  = mem_size_i;
      uns_d   = mem_unsigned_i;
      write_d = mem_write_i;
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
    if (fire & ~acc_write) rdata_d = misaligned ? 32'h0 : ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    write_q <= write_d;
  end

`ifdef DMEM_MISALIGN_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (fire)                      err_d = misaligned;
    else if (state_q == ST_DONE)   err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`endif

  // FSM outputs
  always_comb begin
    mem_ready_o = (state_q == ST_DONE);
    mem_busy_o  = accept | (state_q == ST_WAIT);
`ifdef DMEM_MISALIGN_ERR_EN
    mem_err_o   = (state_q == ST_DONE) & err_q;
`else
    mem_err_o   = 1'b0;
`endif
  end

  assign mem_rdata_o = rdata_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder at the far end of the MEM-stage load/store interface of the RV32IM pipeline. It accepts a load or store from the MEM stage and holds it for a fixed, parameterised latency. It then commits the store or returns the extended load data. It raises a stall to the hazard unit while the access is in flight. Storage is an internal word array with byte and halfword lane handling.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, 16..65536.
- LATENCY, 2: cycles from acceptance to response; 1..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read_i  in  1  load request (MEM stage).
- mem_write_i  in  1  store request; has priority if both read and write are high.
- mem_addr_i  in  32  byte address (ALU result).
- mem_wdata_i  in  32  store data (rs2); the low byte or low half is used for sub-word stores.
- mem_size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- mem_unsigned_i  in  1  load extension: 1 zero-extends, 0 sign-extends.
- mem_ready_o  out  1  one-cycle response pulse.
- mem_rdata_o  out  32  extended load data; holds its value until the next load response.
- mem_busy_o  out  1  stall request to the hazard unit.
- mem_err_o  out  1  misaligned-access flag (see Configuration).

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - A request is present when (mem_read_i | mem_write_i) is high.
  - On a request, latch the address, write data, size, unsigned flag and direction.
  - Load the counter with LATENCY-1.
  - Go to WAIT, or go directly to DONE when LATENCY=1.
- WAIT: decrement the counter. When it reaches 0, perform the access on that edge and go to DONE.
- DONE:
  - mem_ready_o is 1. For a load, mem_rdata_o is valid.
  - Always return to IDLE.
  - A request present in DONE is not accepted, because it is still the old instruction held by the stall. It is accepted on the following cycle if it is still present.
- mem_busy_o = (state==IDLE & request) | state==WAIT. It is 0 in DONE so the pipeline advances.
- Address decode:
  - Word index = mem_addr_i[log2(DEPTH_WORDS)+1:2]; higher bits are ignored, so addresses wrap modulo the array size.
  - Byte lane = addr[1:0]; half lane = addr[1].
- Stores write only the addressed lanes; the other bytes in the word are preserved.
- Loads:
  - Select the addressed lane, extend it to 32 bits per mem_unsigned_i, and register the result into mem_rdata_o.
  - A store response leaves mem_rdata_o unchanged.
- Request inputs are sampled only on acceptance. Changes to them while in WAIT are ignored.

## Timing
- Acceptance edge is cycle N. mem_ready_o is high in cycle N+LATENCY.
- Throughput is one access per LATENCY+1 cycles.
- A store is visible to a load accepted at or after its DONE cycle.
- Reset values: state IDLE, counter 0, mem_ready_o 0, mem_rdata_o 0, mem_busy_o 0 (with no request present), mem_err_o 0.
- Array contents are not reset.
- Reset asserted mid-access aborts the access. An uncommitted store is never written, and no ready pulse follows.

## Configuration
- DMEM_MISALIGN_ERR_EN defined:
  - Misaligned means a half access with addr[0]=1, or a word access with addr[1:0]!=0.
  - A misaligned access performs no write.
  - The response has mem_err_o=1 together with mem_ready_o.
  - For a misaligned load, mem_rdata_o is 0.
  - Latency is unchanged.
- DMEM_MISALIGN_ERR_EN undefined:
  - mem_err_o is tied to 0.
  - Misaligned addresses are forced aligned: a half access uses addr[1] only; a word access ignores addr[1:0].

## Structure
- Shared package dmem_pkg holds:
  - Size encodings SIZE_B, SIZE_H, SIZE_W.
  - State encodings ST_IDLE, ST_WAIT, ST_DONE.
  - The LATENCY width constant (4 bits).
- Sub-module dmem_lane_align: combinational logic for store byte-enable and data shift, and for load lane select and extension. It is instantiated once.

## Test plan
- LATENCY=2; store word 0xDEADBEEF at 0x10, then load word from 0x10. Required: busy is high 2 cycles per access, ready pulses in cycle N+2, rdata=0xDEADBEEF.
- Store byte 0x80 at 0x13, then load byte from 0x13 signed and unsigned. Required: 0xFFFFFF80, then 0x00000080; word 0x10 becomes 0x80ADBEEF.
- Store half 0x1234 at 0x22; load half from 0x22. Required: 0x00001234; bytes 0x20–0x21 are unchanged.
- DEPTH_WORDS=16; store at 0x40, then load from 0x00. Required: same data (wrap).
- With DMEM_MISALIGN_ERR_EN, store word to 0x11. Required: err=1 with ready, memory unchanged. Without the macro, the same store writes word 0x10.
- rst_n low in the WAIT cycle of a store. Required: no ready pulse, outputs 0, and a later load returns the old contents.
